// File: rtl/queue_fir_mac.sv
`default_nettype none
// ============================================================================
//  Module   : queue_fir_mac
//  Brief    : Sequential FIR multiply-accumulate fed by a circular sample
//             queue. Each queued sample is multiplied by the coefficient
//             at its index in an external ROM. The 42-bit sum is shifted
//             down to Q1.15 and saturated when the sequence ends.
//  Revision : 1.0 - initial release
// ============================================================================
module queue_fir_mac #(
  parameter int TAPS   = 1021,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       smpl_out,
  input  logic              sequencing,
  input  logic [15:0]       coeff,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic [15:0]       filt_out,
  output logic              filt_vld,
  output logic              ovr
);

  // Highest valid coefficient index. The address parks here once the table
  // has been used up.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TAPS - 1);

  // Saturation bounds for the Q1.15 result, in accumulator width.
  localparam logic signed [41:0] SAT_POS = 42'sd32767;
  localparam logic signed [41:0] SAT_NEG = -42'sd32768;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                   state_q;
  logic [ADDR_W-1:0]        coeff_addr_q;
  logic signed [31:0]       prod_q;
  logic                     prod_vld_q;
  logic signed [41:0]       acc_q;
  logic                     tbl_full_q;   // last coefficient already used
  logic [15:0]              filt_out_q;
  logic                     filt_vld_q;
  logic                     ovr_q;

  logic signed [31:0]       prod_d;
  logic signed [41:0]       prod_ext_d;
  logic signed [41:0]       acc_d;
  logic signed [41:0]       acc_shr_d;
  logic [15:0]              filt_sat_d;
  logic                     at_last_d;

  // Full-precision signed product of the current sample and coefficient.
  assign prod_d = 32'($signed(smpl_out)) * 32'($signed(coeff));

  // A product is added only when one is pending from the previous cycle.
  assign prod_ext_d = prod_vld_q ? {{10{prod_q[31]}}, prod_q} : '0;
  assign acc_d      = acc_q + prod_ext_d;

  // Rescale the accumulator back to Q1.15.
  assign acc_shr_d  = acc_q >>> 15;

  // The address stops advancing once the last table entry is reached.
  assign at_last_d  = (coeff_addr_q == LAST_ADDR);

  // Clamp the rescaled sum into the 16-bit signed output range.
  always_comb begin
    filt_sat_d = acc_shr_d[15:0];
    if (acc_shr_d > SAT_POS) begin
      filt_sat_d = 16'h7FFF;
    end else if (acc_shr_d < SAT_NEG) begin
      filt_sat_d = 16'h8000;
    end
  end

  // Sequencer: IDLE waits for a sample, ACCUM multiplies and accumulates,
  // DRAIN publishes the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      coeff_addr_q <= '0;
      prod_q       <= '0;
      prod_vld_q   <= 1'b0;
      acc_q        <= '0;
      tbl_full_q   <= 1'b0;
      filt_out_q   <= 16'h0000;
      filt_vld_q   <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      filt_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sequencing) begin
            // First sample of a sequence: start from an empty sum.
            state_q    <= S_ACCUM;
            acc_q      <= '0;
            prod_q     <= prod_d;
            prod_vld_q <= 1'b1;
            if (at_last_d) begin
              tbl_full_q <= 1'b1;
            end else begin
              coeff_addr_q <= coeff_addr_q + 1'b1;
            end
          end
        end

        S_ACCUM: begin
          acc_q <= acc_d;
          if (sequencing) begin
            prod_q     <= prod_d;
            prod_vld_q <= 1'b1;
            if (tbl_full_q) begin
              // More samples than coefficients: keep going on the last
              // coefficient and flag it.
              ovr_q <= 1'b1;
            end else if (at_last_d) begin
              tbl_full_q <= 1'b1;
            end else begin
              coeff_addr_q <= coeff_addr_q + 1'b1;
            end
          end else begin
            // Sequence ended: the final product is folded in this cycle.
            state_q      <= S_DRAIN;
            prod_vld_q   <= 1'b0;
            coeff_addr_q <= '0;
            tbl_full_q   <= 1'b0;
          end
        end

        S_DRAIN: begin
          filt_out_q <= filt_sat_d;
          filt_vld_q <= 1'b1;
          state_q    <= S_IDLE;
          if (sequencing) begin
            // A sample arriving while the result is published is lost.
            ovr_q <= 1'b1;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          coeff_addr_q <= '0;
          prod_vld_q   <= 1'b0;
          tbl_full_q   <= 1'b0;
        end
      endcase
    end
  end

  assign coeff_addr = coeff_addr_q;
  assign filt_out   = filt_out_q;
  assign filt_vld   = filt_vld_q;
  assign ovr        = ovr_q;

endmodule
`default_nettype wire
